gb_if_arbiter: RTL and testbench
================================

Name: gb_if_arbiter

Overview:
- Parametrised arbiter for the single shared off-chip interface (IF) port of the global buffer.
- Serves NUM_CH requesters, e.g. config loader, pooling flag writer, pooling data writer and SRAM block loaders.
- Each transaction is one config handshake followed by a counted burst of data beats, either IF->channel (read) or channel->IF (write).
- The port stays locked to one channel until its burst completes.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- PORT_WIDTH, 128, data beat width in bits.
- TYPE_WIDTH, 3, data-type tag width; forwarded to the IF in the cfg info word.
- LEN_WIDTH, 8, burst length field width; beats = len+1.
- CH_W, 3, width of the grant index; must be at least clog2(NUM_CH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CCUGB_reset_all  in  1  synchronous abort; returns the block to IDLE
- CHGB_req_val  in  NUM_CH  per-channel request valid
- GBCH_req_rdy  out  NUM_CH  one-hot request accept
- CHGB_req_dir  in  NUM_CH  per-channel direction; 1=read (IF->GB), 0=write (GB->IF)
- CHGB_req_type  in  NUM_CH*TYPE_WIDTH  packed data-type tags
- CHGB_req_len  in  NUM_CH*LEN_WIDTH  packed burst lengths, value is beats-1
- GBIF_cfg_val  out  1  cfg valid to IF
- IFGB_cfg_rdy  in  1  cfg ready from IF
- GBIF_cfg_info  out  TYPE_WIDTH+1  {type, dir}
- GBIF_cfg_len  out  LEN_WIDTH  latched length
- CHGB_wr_val  in  NUM_CH  write beat valid from channel
- CHGB_wr_data  in  NUM_CH*PORT_WIDTH  packed write data
- GBCH_wr_rdy  out  NUM_CH  write ready to channel
- GBIF_wr_val  out  1  write beat valid to IF
- GBIF_wr_data  out  PORT_WIDTH  write data to IF
- IFGB_wr_rdy  in  1  IF write ready
- IFGB_rd_val  in  1  read beat valid from IF
- IFGB_rd_data  in  PORT_WIDTH  read data from IF
- GBIF_rd_rdy  out  1  read ready to IF
- GBCH_rd_val  out  NUM_CH  read beat valid, one-hot to granted channel
- GBCH_rd_data  out  PORT_WIDTH  read data, broadcast to all channels
- CHGB_rd_rdy  in  NUM_CH  channel read ready
- GBCCU_busy  out  1  high in CFG or DATA
- GBCCU_grant_ch  out  CH_W  index of current/last granted channel

Behaviour:
- Reset (rst_n low): state=IDLE, beat counter=0, latched info/len=0, GBCCU_grant_ch=0.
- All outputs are 0 during and after reset until a grant occurs.
- IDLE:
  - If any CHGB_req_val bit is set, pick the winner g by the arbitration policy.
  - GBCH_req_rdy[g]=1 combinationally in the same cycle; all other bits stay 0.
  - Latch type/dir/len of g and set GBCCU_grant_ch=g.
  - Next cycle -> CFG.
- CFG:
  - GBIF_cfg_val=1 (registered) with latched info and len; held stable until IFGB_cfg_rdy.
  - On the cfg handshake: beat counter = len, next state DATA.
- DATA, write (dir=0):
  - GBIF_wr_val = CHGB_wr_val[g], GBIF_wr_data = slice g, GBCH_wr_rdy[g] = IFGB_wr_rdy. Pure combinational pass-through, zero latency.
- DATA, read (dir=1):
  - GBCH_rd_val[g] = IFGB_rd_val, GBIF_rd_rdy = CHGB_rd_rdy[g], GBCH_rd_data = IFGB_rd_data.
- Outside DATA, or for non-granted channels: all data valid/ready outputs are 0. GBCH_rd_data is 0 outside DATA-read.
- Beat counting:
  - Decrement on each data handshake.
  - A handshake with counter=0 is the last beat; next state IDLE.
  - len=0 gives exactly one beat; len=2^LEN_WIDTH-1 gives 2^LEN_WIDTH beats, with no counter wrap.
- Turnaround: at least one IDLE cycle between bursts; back-to-back requests cost 2 overhead cycles (IDLE + CFG minimum).
- Requests arriving in CFG/DATA are not accepted; they are held by the channels (valid must stay high until accepted).
- CCUGB_reset_all:
  - In any state: next cycle IDLE, counter=0, cfg/data valids deasserted, GBCH_req_rdy forced 0 in the same cycle.
  - An in-flight burst is dropped without completion.
  - It has priority over a simultaneous handshake.
- The IFGB_cfg_rdy and data handshake never coincide; they belong to different states.

Optional Feature:
- Macro GB_IF_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last granted index + 1) mod NUM_CH. The last-grant register resets to NUM_CH-1, so channel 0 wins first.
- Undefined: fixed priority; lowest set index wins and no pointer register is built.

Test Plan:
- Single write, NUM_CH=4:
  - Stimulus: ch2 requests dir=0, type=5, len=3; IF always ready.
  - Response: req_rdy=4'b0100 in the accept cycle; cfg_info=4'b1010, cfg_len=3; exactly 4 beats forwarded; IDLE on the cycle after the 4th beat; busy high for 5 cycles.
- Read with backpressure:
  - Stimulus: ch0 read, len=1; IFGB_rd_val toggling; CHGB_rd_rdy[0] low on the first valid.
  - Response: GBIF_rd_rdy mirrors rd_rdy; exactly 2 accepted beats; data matches the IF.
- Simultaneous requests:
  - Stimulus: all 4 channels requesting with len=0.
  - Response, fixed priority: grant order 0,0,0… while ch0 keeps requesting.
  - Response, GB_IF_ARB_RR_EN: grant order 0,1,2,3.
- cfg stall:
  - Stimulus: IFGB_cfg_rdy held low for 5 cycles.
  - Response: cfg_val/info/len stay stable; no data beats pass.
- Abort mid-burst:
  - Stimulus: CCUGB_reset_all pulsed after 2 of 8 beats.
  - Response: next cycle IDLE; all valids 0; a new request is then granted normally.
- Max length:
  - Stimulus: len=255.
  - Response: exactly 256 beats; no early release.

Source files
------------

// File: rtl/gb_if_arbiter_if.sv
// Bundle of the shared off-chip IF port handshakes and the per-channel request/data buses.
// The master modport is the arbiter's view; the slave modport is the channels/IF/CCU side.
interface gb_if_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int PORT_WIDTH = 128,
    parameter int TYPE_WIDTH = 3,
    parameter int LEN_WIDTH  = 8,
    parameter int CH_W       = 3
) ();
    logic                           CCUGB_reset_all;
    logic [NUM_CH-1:0]              CHGB_req_val;
    logic [NUM_CH-1:0]              GBCH_req_rdy;
    logic [NUM_CH-1:0]              CHGB_req_dir;
    logic [NUM_CH*TYPE_WIDTH-1:0]   CHGB_req_type;
    logic [NUM_CH*LEN_WIDTH-1:0]    CHGB_req_len;
    logic                           GBIF_cfg_val;
    logic                           IFGB_cfg_rdy;
    logic [TYPE_WIDTH:0]            GBIF_cfg_info;
    logic [LEN_WIDTH-1:0]           GBIF_cfg_len;
    logic [NUM_CH-1:0]              CHGB_wr_val;
    logic [NUM_CH*PORT_WIDTH-1:0]   CHGB_wr_data;
    logic [NUM_CH-1:0]              GBCH_wr_rdy;
    logic                           GBIF_wr_val;
    logic [PORT_WIDTH-1:0]          GBIF_wr_data;
    logic                           IFGB_wr_rdy;
    logic                           IFGB_rd_val;
    logic [PORT_WIDTH-1:0]          IFGB_rd_data;
    logic                           GBIF_rd_rdy;
    logic [NUM_CH-1:0]              GBCH_rd_val;
    logic [PORT_WIDTH-1:0]          GBCH_rd_data;
    logic [NUM_CH-1:0]              CHGB_rd_rdy;
    logic                           GBCCU_busy;
    logic [CH_W-1:0]                GBCCU_grant_ch;

    modport master (
        input  CCUGB_reset_all, CHGB_req_val, CHGB_req_dir, CHGB_req_type, CHGB_req_len,
               IFGB_cfg_rdy, CHGB_wr_val, CHGB_wr_data, IFGB_wr_rdy,
               IFGB_rd_val, IFGB_rd_data, CHGB_rd_rdy,
        output GBCH_req_rdy, GBIF_cfg_val, GBIF_cfg_info, GBIF_cfg_len,
               GBCH_wr_rdy, GBIF_wr_val, GBIF_wr_data, GBIF_rd_rdy,
               GBCH_rd_val, GBCH_rd_data, GBCCU_busy, GBCCU_grant_ch
    );

    modport slave (
        output CCUGB_reset_all, CHGB_req_val, CHGB_req_dir, CHGB_req_type, CHGB_req_len,
               IFGB_cfg_rdy, CHGB_wr_val, CHGB_wr_data, IFGB_wr_rdy,
               IFGB_rd_val, IFGB_rd_data, CHGB_rd_rdy,
        input  GBCH_req_rdy, GBIF_cfg_val, GBIF_cfg_info, GBIF_cfg_len,
               GBCH_wr_rdy, GBIF_wr_val, GBIF_wr_data, GBIF_rd_rdy,
               GBCH_rd_val, GBCH_rd_data, GBCCU_busy, GBCCU_grant_ch
    );
endinterface

// File: rtl/gb_if_arbiter.sv
// Arbiter for the global buffer's single off-chip IF port: one cfg handshake, then a counted burst.
// Define GB_IF_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
//
//   state   | meaning
//   IDLE    | waiting for a request; winner accepted combinationally and latched
//   CFG     | cfg_val high with latched {type,dir} and len until IFGB_cfg_rdy
//   DATA    | beats forwarded between IF and granted channel; counter hits 0 on last beat
module gb_if_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int PORT_WIDTH = 128,
    parameter int TYPE_WIDTH = 3,
    parameter int LEN_WIDTH  = 8,
    parameter int CH_W       = 3
) (
    input  logic clk,
    input  logic rst_n,
    gb_if_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [TYPE_WIDTH:0]    r_info;
    logic [CH_W-1:0]        r_grant;
    logic [CH_W-1:0]        w_win;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_hs;
    logic [TYPE_WIDTH-1:0]  w_sel_type;
    logic                   w_sel_dir;
    logic [LEN_WIDTH-1:0]   w_sel_len;

`ifdef GB_IF_ARB_RR_EN
    logic [CH_W-1:0]        r_last;
    int                     w_dist, w_best;

    // Winner is the requester at the smallest circular distance after the last grant.
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_best = NUM_CH;
        w_dist = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_dist = i - int'(r_last) - 1;
            if (w_dist < 0) w_dist = w_dist + NUM_CH;
            if (bus.CHGB_req_val[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = CH_W'(i);
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= CH_W'(NUM_CH - 1);
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`else
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.CHGB_req_val[i]) begin
                w_win = CH_W'(i);
                w_any = 1'b1;
            end
        end
    end
`endif

    assign w_accept = (r_state == ST_IDLE) && w_any && !bus.CCUGB_reset_all;

    always_comb begin
        w_sel_type = '0;
        w_sel_dir  = 1'b0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == CH_W'(i)) begin
                w_sel_type = bus.CHGB_req_type[i*TYPE_WIDTH +: TYPE_WIDTH];
                w_sel_dir  = bus.CHGB_req_dir[i];
                w_sel_len  = bus.CHGB_req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Data path is a zero-latency pass-through to the granted channel only.
    always_comb begin
        bus.GBCH_req_rdy = '0;
        bus.GBIF_wr_val  = 1'b0;
        bus.GBIF_wr_data = '0;
        bus.GBCH_wr_rdy  = '0;
        bus.GBIF_rd_rdy  = 1'b0;
        bus.GBCH_rd_val  = '0;
        bus.GBCH_rd_data = '0;
        w_hs             = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_accept && (w_win == CH_W'(i))) bus.GBCH_req_rdy[i] = 1'b1;
        end
        if (r_state == ST_DATA) begin
            if (r_info[0]) begin
                bus.GBCH_rd_data = bus.IFGB_rd_data;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_grant == CH_W'(i)) begin
                        bus.GBCH_rd_val[i] = bus.IFGB_rd_val;
                        bus.GBIF_rd_rdy    = bus.CHGB_rd_rdy[i];
                    end
                end
                w_hs = bus.IFGB_rd_val && bus.GBIF_rd_rdy;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_grant == CH_W'(i)) begin
                        bus.GBIF_wr_val    = bus.CHGB_wr_val[i];
                        bus.GBIF_wr_data   = bus.CHGB_wr_data[i*PORT_WIDTH +: PORT_WIDTH];
                        bus.GBCH_wr_rdy[i] = bus.IFGB_wr_rdy;
                    end
                end
                w_hs = bus.GBIF_wr_val && bus.IFGB_wr_rdy;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_CFG;
            end
            ST_CFG: begin
                if (bus.IFGB_cfg_rdy) begin
                    w_cnt_nxt   = r_len;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over any handshake landing in the same cycle.
        if (bus.CCUGB_reset_all) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_info  <= '0;
            r_len   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_info  <= {w_sel_type, w_sel_dir};
                r_len   <= w_sel_len;
                r_grant <= w_win;
            end
        end
    end

    assign bus.GBIF_cfg_val   = (r_state == ST_CFG);
    assign bus.GBIF_cfg_info  = r_info;
    assign bus.GBIF_cfg_len   = r_len;
    assign bus.GBCCU_busy     = (r_state != ST_IDLE);
    assign bus.GBCCU_grant_ch = r_grant;

endmodule

// File: tb/tb_gb_if_arbiter.sv
// Randomized bench for gb_if_arbiter: transaction-level model of arbitration order and beat counts.
// Follows GB_IF_ARB_RR_EN the same way the design does.
module tb_gb_if_arbiter;
    localparam int NCH = 4;
    localparam int PW  = 128;
    localparam int TW  = 3;
    localparam int LW  = 8;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gb_if_arbiter_if #(.NUM_CH(NCH), .PORT_WIDTH(PW), .TYPE_WIDTH(TW), .LEN_WIDTH(LW), .CH_W(CW)) bus ();

    gb_if_arbiter #(.NUM_CH(NCH), .PORT_WIDTH(PW), .TYPE_WIDTH(TW), .LEN_WIDTH(LW), .CH_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    bit            pend   [NCH];
    logic          c_dir  [NCH];
    logic [TW-1:0] c_type [NCH];
    logic [LW-1:0] c_len  [NCH];
    int            last_g = NCH - 1;

    task automatic check(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick();
`ifdef GB_IF_ARB_RR_EN
        for (int k = 1; k <= NCH; k++)
            if (pend[(last_g + k) % NCH]) return (last_g + k) % NCH;
`else
        for (int i = 0; i < NCH; i++)
            if (pend[i]) return i;
`endif
        return -1;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NCH; i++) begin
            bus.CHGB_req_val[i]          = pend[i];
            bus.CHGB_req_dir[i]          = c_dir[i];
            bus.CHGB_req_type[i*TW +: TW] = c_type[i];
            bus.CHGB_req_len[i*LW +: LW]  = c_len[i];
        end
    endtask

    function automatic logic [PW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_data();
        bus.CHGB_wr_val  = '0;
        bus.CHGB_rd_rdy  = '0;
        bus.IFGB_wr_rdy  = 1'b0;
        bus.IFGB_rd_val  = 1'b0;
        bus.IFGB_cfg_rdy = 1'b0;
    endtask

    // Called just after a falling edge in IDLE; grants per model, runs cfg and data phases.
    task automatic serve(input bit keep, input int stall, input int pv, input int pr, input int abort_at);
        int              g, beats, cyc;
        bit              aborted, hs;
        logic [NCH-1:0]  oh, wv, rr;
        logic            ifv, ifr;
        logic [PW-1:0]   ifd;
        logic [PW-1:0]   wd [NCH];
        drive_req();
        #1;
        g = pick();
        if (g < 0) begin
            check("have_request", 1'b0, 1'b1);
            return;
        end
        oh    = '0;
        oh[g] = 1'b1;
        check("req_rdy", bus.GBCH_req_rdy, oh);
        check("busy_idle", bus.GBCCU_busy, 1'b0);
        last_g = g;
        @(negedge clk);
        if (!keep) begin
            pend[g] = 1'b0;
            drive_req();
        end
        // Channel and IF signals held active in CFG to catch leaks into the data path.
        bus.CHGB_wr_val  = '1;
        bus.CHGB_rd_rdy  = '1;
        bus.IFGB_wr_rdy  = 1'b1;
        bus.IFGB_rd_val  = 1'b1;
        bus.IFGB_rd_data = rnd_word() | 1;
        for (int s = 0; s <= stall; s++) begin
            bus.IFGB_cfg_rdy = (s == stall);
            #1;
            check("grant_ch", bus.GBCCU_grant_ch, g);
            check("busy_cfg", bus.GBCCU_busy, 1'b1);
            check("cfg_val", bus.GBIF_cfg_val, 1'b1);
            check("cfg_info", bus.GBIF_cfg_info, {c_type[g], c_dir[g]});
            check("cfg_len", bus.GBIF_cfg_len, c_len[g]);
            check("cfg_no_data", {bus.GBIF_wr_val, bus.GBCH_rd_val, bus.GBIF_rd_rdy, bus.GBCH_wr_rdy}, '0);
            check("cfg_rd_data", bus.GBCH_rd_data, '0);
            @(negedge clk);
        end
        bus.IFGB_cfg_rdy = 1'b0;
        beats   = 0;
        cyc     = 0;
        aborted = 1'b0;
        while (beats <= int'(c_len[g]) && cyc < 3000) begin
            if (abort_at >= 0 && beats == abort_at) begin
                bus.CCUGB_reset_all = 1'b1;
                #1;
                check("rdy_abort", bus.GBCH_req_rdy, '0);
                @(negedge clk);
                bus.CCUGB_reset_all = 1'b0;
                aborted = 1'b1;
                break;
            end
            for (int i = 0; i < NCH; i++) begin
                wv[i] = ($urandom_range(99) < pv);
                rr[i] = ($urandom_range(99) < pr);
                wd[i] = rnd_word();
                bus.CHGB_wr_data[i*PW +: PW] = wd[i];
            end
            ifv = ($urandom_range(99) < pv);
            ifr = ($urandom_range(99) < pr);
            ifd = rnd_word();
            bus.CHGB_wr_val  = wv;
            bus.CHGB_rd_rdy  = rr;
            bus.IFGB_rd_val  = ifv;
            bus.IFGB_wr_rdy  = ifr;
            bus.IFGB_rd_data = ifd;
            #1;
            check("busy_data", bus.GBCCU_busy, 1'b1);
            check("cfg_val_data", bus.GBIF_cfg_val, 1'b0);
            if (c_dir[g]) begin
                check("rd_val", bus.GBCH_rd_val, ifv ? oh : '0);
                check("rd_rdy", bus.GBIF_rd_rdy, rr[g]);
                check("rd_data", bus.GBCH_rd_data, ifd);
                check("rd_no_wr", {bus.GBIF_wr_val, bus.GBCH_wr_rdy}, '0);
                hs = ifv && rr[g];
            end else begin
                check("wr_val", bus.GBIF_wr_val, wv[g]);
                check("wr_data", bus.GBIF_wr_data, wd[g]);
                check("wr_rdy", bus.GBCH_wr_rdy, ifr ? oh : '0);
                check("wr_no_rd", {bus.GBCH_rd_val, bus.GBIF_rd_rdy}, '0);
                hs = wv[g] && ifr;
            end
            if (hs) beats++;
            @(negedge clk);
            cyc++;
        end
        clear_data();
        #1;
        check("beats", beats, aborted ? abort_at : int'(c_len[g]) + 1);
        check("busy_after", bus.GBCCU_busy, 1'b0);
        check("valids_after", {bus.GBIF_cfg_val, bus.GBIF_wr_val, bus.GBCH_rd_val, bus.GBIF_rd_rdy, bus.GBCH_wr_rdy}, '0);
        check("rd_data_after", bus.GBCH_rd_data, '0);
    endtask

    task automatic set_ch(input int ch, input logic dir, input int typ, input int len);
        pend[ch]   = 1'b1;
        c_dir[ch]  = dir;
        c_type[ch] = TW'(typ);
        c_len[ch]  = LW'(len);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npend;
        rst_n               = 1'b0;
        bus.CCUGB_reset_all = 1'b0;
        bus.CHGB_wr_data    = '0;
        bus.IFGB_rd_data    = '0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 1'b0; c_dir[i] = 1'b0; c_type[i] = '0; c_len[i] = '0;
        end
        drive_req();
        clear_data();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.GBCCU_busy, 1'b0);
        check("rst_grant", bus.GBCCU_grant_ch, '0);
        check("rst_cfg", {bus.GBIF_cfg_val, bus.GBIF_cfg_info, bus.GBIF_cfg_len}, '0);
        check("rst_req_rdy", bus.GBCH_req_rdy, '0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_outputs", {bus.GBCCU_busy, bus.GBIF_cfg_val, bus.GBIF_wr_val, bus.GBCH_rd_val}, '0);

        // single write on ch2: type 5, len 3
        set_ch(2, 1'b0, 5, 3);
        serve(1'b0, 0, 100, 100, -1);

        // read on ch0 with random backpressure on both sides
        set_ch(0, 1'b1, 2, 1);
        serve(1'b0, 0, 50, 50, -1);

        // all four request single beats; winners keep requesting
        for (int i = 0; i < NCH; i++) set_ch(i, 1'(i & 1), i, 0);
        for (int n = 0; n < NCH; n++) serve(1'b1, 0, 100, 100, -1);
        for (int i = 0; i < NCH; i++) pend[i] = 1'b0;

        // cfg stall of 5 cycles
        set_ch(1, 1'b0, 3, 2);
        serve(1'b0, 5, 100, 100, -1);

        // abort in IDLE blocks the grant
        set_ch(3, 1'b1, 6, 7);
        drive_req();
        bus.CCUGB_reset_all = 1'b1;
        #1;
        check("rdy_forced0", bus.GBCH_req_rdy, '0);
        @(negedge clk);
        bus.CCUGB_reset_all = 1'b0;
        #1;
        check("no_grant_abort", bus.GBCCU_busy, 1'b0);

        // abort after 2 of 8 beats, then a normal grant
        set_ch(1, 1'b0, 4, 7);
        serve(1'b0, 0, 100, 100, 2);
        serve(1'b0, 0, 100, 100, -1);

        // maximum length burst
        set_ch(2, 1'b0, 7, 255);
        serve(1'b0, 0, 100, 100, -1);

        for (int t = 0; t < 40; t++) begin
            npend = 0;
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && ($urandom_range(1) == 1))
                    set_ch(i, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(15));
                if (pend[i]) npend++;
            end
            if (npend == 0) set_ch($urandom_range(NCH - 1), 1'b1, 1, 4);
            serve(1'b0, $urandom_range(2), $urandom_range(60, 100), $urandom_range(60, 100), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
